// File: rtl/ik_pkg.sv
// ik_pkg: shared fixed-point widths, vector/matrix types and stage state encoding
package ik_pkg;
  localparam int FIXED_W = 36;
  localparam int FRAC_BITS = 20;
  localparam int ACC_W = 48;
  localparam int NJ = 6;
  typedef logic signed [FIXED_W-1:0] fixed_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef fixed_t [NJ-1:0] vec6_t;
  typedef fixed_t [NJ-1:0][NJ-1:0] mat6_t;
  typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} jts_state_e;
endpackage

// File: rtl/fixed_mul_sat.sv
// fixed_mul_sat: full-width signed multiply, floor shift by SHIFT, saturate to OUT_W with clamp flag
module fixed_mul_sat #(
  parameter int A_W = 36,
  parameter int B_W = 36,
  parameter int OUT_W = 36,
  parameter int SHIFT = 20
) (
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);
  localparam int P_W = A_W + B_W;
  logic signed [P_W-1:0] p, s;
  logic [P_W-OUT_W:0] hi;
  assign p = P_W'(a) * P_W'(b);
  assign s = p >>> SHIFT;
  // the shifted value fits only if every bit above the output sign bit repeats it
  assign hi = s[P_W-1:OUT_W-1];
  assign ovf = !(&hi || !(|hi));
  assign y = ovf ? {s[P_W-1], {(OUT_W-1){~s[P_W-1]}}} : s[OUT_W-1:0];
endmodule

// File: rtl/jacobian_transpose_step.sv
// jacobian_transpose_step: dtheta = alpha * J^T * e using one time-shared saturating MAC
module jacobian_transpose_step
  import ik_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   start,
  input  mat6_t  jacobian_matrix,
  input  vec6_t  error,
  input  fixed_t alpha,
  output logic   busy,
  output logic   done,
  output vec6_t  dtheta,
  output logic   overflow
);
  jts_state_e state;
  logic [2:0] i, j;
  mat6_t j_r;
  vec6_t e_r;
  fixed_t a_r;
  acc_t acc, prod, sum_sat;
  fixed_t scl;
  logic prod_ovf, scl_ovf, add_ovf;
  logic [ACC_W:0] sum;
  fixed_mul_sat #(.A_W(FIXED_W), .B_W(FIXED_W), .OUT_W(ACC_W), .SHIFT(FRAC_BITS)) u_mac (
    .a(j_r[i][j]), .b(e_r[i]), .y(prod), .ovf(prod_ovf)
  );
  fixed_mul_sat #(.A_W(FIXED_W), .B_W(ACC_W), .OUT_W(FIXED_W), .SHIFT(FRAC_BITS)) u_scale (
    .a(a_r), .b(acc), .y(scl), .ovf(scl_ovf)
  );
  assign sum = {acc[ACC_W-1], acc} + {prod[ACC_W-1], prod};
  assign add_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_sat = add_ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
  // sequencer: capture operands, accumulate one column over six rows, scale, repeat per column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      j_r <= '0;
      e_r <= '0;
      a_r <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dtheta <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (start) begin
          j_r <= jacobian_matrix;
          e_r <= error;
          a_r <= alpha;
          overflow <= 1'b0;
          i <= '0;
          j <= '0;
          acc <= '0;
          busy <= 1'b1;
          state <= MAC;
        end
        MAC: begin
          acc <= sum_sat;
          overflow <= overflow | prod_ovf | add_ovf;
          i <= (i == 3'd5) ? 3'd0 : i + 3'd1;
          state <= (i == 3'd5) ? SCALE : MAC;
        end
        SCALE: begin
          dtheta[j] <= scl;
          overflow <= overflow | scl_ovf;
          acc <= '0;
          j <= (j == 3'd5) ? j : j + 3'd1;
          state <= (j == 3'd5) ? DONE : MAC;
          done <= (j == 3'd5);
          busy <= (j != 3'd5);
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jacobian_transpose_step.sv
// tb_jacobian_transpose_step: directed runs checked against a cycle/arithmetic reference model
module tb_jacobian_transpose_step;
  import ik_pkg::*;
  localparam fixed_t ONE = 36'h0_0010_0000;
  localparam fixed_t HALF = 36'h0_0008_0000;
  localparam fixed_t MAXV = 36'h7_FFFF_FFFF;
  localparam fixed_t MINV = 36'h8_0000_0000;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0;
  mat6_t jm = '0;
  vec6_t ev = '0;
  fixed_t al = '0;
  logic busy, done, overflow;
  vec6_t dth;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  jacobian_transpose_step dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .jacobian_matrix(jm), .error(ev), .alpha(al),
    .busy(busy), .done(done), .dtheta(dth), .overflow(overflow)
  );
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  // reference arithmetic: plain wide integers with clamps at each stated saturation point
  logic m_ov;
  function automatic logic signed [127:0] clamp(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi_v, lo_v;
    hi_v = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo_v = -hi_v - 128'sd1;
    if (v > hi_v) begin m_ov = 1'b1; return hi_v; end
    if (v < lo_v) begin m_ov = 1'b1; return lo_v; end
    return v;
  endfunction
  vec6_t res;
  logic res_ov;
  task automatic model_run();
    logic signed [127:0] acc, p, s;
    m_ov = 1'b0;
    for (int c = 0; c < 6; c++) begin
      acc = 0;
      for (int r = 0; r < 6; r++) begin
        p = ($signed(jm[r][c]) * $signed(ev[r])) >>> 20;
        acc = clamp(acc + clamp(p, 48), 48);
      end
      s = clamp(($signed(al) * acc) >>> 20, 36);
      res[c] = s[35:0];
    end
    res_ov = m_ov;
  endtask
  // reference timing: result appears 42 enabled edges after the capturing edge, done for one enabled cycle
  int ph = -1;
  logic e_busy = 1'b0, e_done = 1'b0, e_ov = 1'b0;
  vec6_t e_dth = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = -1; e_busy = 1'b0; e_done = 1'b0; e_ov = 1'b0; e_dth = '0;
    end else if (en) begin
      if (ph < 0) begin
        if (start) begin model_run(); ph = 0; e_busy = 1'b1; end
      end else if (ph < 42) begin
        ph++;
        if (ph == 42) begin e_busy = 1'b0; e_done = 1'b1; e_dth = res; e_ov = res_ov; end
      end else begin
        ph = -1; e_done = 1'b0;
      end
    end
  end
  // per-cycle compare; dtheta and overflow are only meaningful outside a run
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (!e_busy) begin
        chk("overflow", overflow, e_ov);
        chk("dtheta", dth, e_dth);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic launch(input mat6_t m, input vec6_t e, input fixed_t a);
    @(negedge clk);
    jm = m; ev = e; al = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  mat6_t ident, half_m, z_m;
  vec6_t e1, ones, half15, exp3;
  int c, dn;
  initial begin
    ident = '0; half_m = '0; z_m = '0;
    for (int r = 0; r < 6; r++) begin
      ident[r][r] = ONE;
      e1[r] = fixed_t'((r + 1) << 20);
      ones[r] = ONE;
      half15[r] = 36'h0_0018_0000;
      for (int k = 0; k < 6; k++) half_m[r][k] = HALF;
    end
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_dtheta", dth, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(ident, e1, ONE);
    wait_done(1, c);
    chk("t1_latency", c, 43);
    chk("t1_dtheta", dth, e1);
    chk("t1_ovf", overflow, 0);
    launch(half_m, ones, HALF);
    wait_done(1, c);
    chk("t2_dtheta", dth, half15);
    chk("t2_ovf", overflow, 0);
    z_m = '0; z_m[0][0] = MAXV;
    exp3 = '0; exp3[0] = MAXV;
    launch(z_m, exp3, ONE);
    wait_done(1, c);
    chk("t3_max_dtheta", dth, exp3);
    chk("t3_max_ovf", overflow, 1);
    exp3[0] = MINV;
    launch(z_m, exp3, ONE);
    wait_done(1, c);
    chk("t3_min_dtheta", dth, exp3);
    chk("t3_min_ovf", overflow, 1);
    launch(ident, e1, ONE);
    tick(9);
    start = 1'b1; ev = '0;
    tick(1);
    start = 1'b0;
    dn = 0;
    for (int k = 0; k < 39; k++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("t4_done_count", dn, 1);
    chk("t4_dtheta", dth, e1);
    launch(half_m, ones, HALF);
    tick(20);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_dtheta", dth, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(ident, e1, ONE);
    wait_done(1, c);
    chk("t5_latency", c, 43);
    chk("t5_dtheta_after", dth, e1);
    launch(half_m, ones, HALF);
    tick(14);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    wait_done(20, c);
    chk("t6_latency", c, 48);
    chk("t6_dtheta", dth, half15);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t6_done_held", done, 1);
    end
    en = 1'b1;
    tick(1);
    chk("t6_done_drop", done, 0);
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
